// File: rtl/motion_sequencer.sv
// motion_sequencer: timed H-bridge maneuver sequencer with dead time and oc lockout.
// Define MOTION_SEQ_QUEUE_EN for a one-deep pending command slot.
module motion_sequencer #(
  parameter int PWM_PERIOD  = 1666667,
  parameter int DEAD_CYCLES = 100000,
  parameter int OC_HOLD     = 5000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [20:0] cmd_duty,
  input  logic [31:0] cmd_dur,
  input  logic        oc,
  output logic        IN1,
  output logic        IN2,
  output logic        IN3,
  output logic        IN4,
  output logic        PWMA,
  output logic        PWMB,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic        fault
);

  localparam logic [20:0] PWM_LAST = 21'(PWM_PERIOD - 1);
  localparam logic [31:0] DEAD_LD  = 32'(DEAD_CYCLES);
  localparam logic [31:0] HOLD_LD  = 32'(OC_HOLD);

  typedef enum logic [1:0] {
    S_IDLE, S_DEAD, S_RUN, S_FAULT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] len_q, len_d;
  logic [20:0] pwm_cnt_q, pwm_cnt_d;
  logic [20:0] duty_q, duty_d;
  logic [3:0]  held_q, held_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  in_q, in_d;
  logic        pwm_q, pwm_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        abt_q, abt_d;
  logic        fault_q, fault_d;
  logic        rdy_q, rdy_d;

  logic        accept, decide, go;
  logic [3:0]  new_pat, src_pat;
  logic [20:0] src_duty;
  logic [31:0] new_len, src_len;

`ifdef MOTION_SEQ_QUEUE_EN
  logic        pend_v_q, pend_v_d;
  logic [3:0]  pend_pat_q, pend_pat_d;
  logic [20:0] pend_duty_q, pend_duty_d;
  logic [31:0] pend_len_q, pend_len_d;
`endif

  always_comb begin
    new_pat = 4'b0000;
    unique case (1'b1)
      cmd_op == 3'd1: new_pat = 4'b1010;
      cmd_op == 3'd2: new_pat = 4'b0101;
      cmd_op == 3'd3: new_pat = 4'b1001;
      cmd_op == 3'd4: new_pat = 4'b0110;
      default:        new_pat = 4'b0000;
    endcase
  end

  assign new_len = (cmd_dur == '0) ? 32'd1 : cmd_dur;
  assign accept  = cmd_valid && rdy_q && !oc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pwm_cnt_d = '0;
    held_d    = held_q;
    pat_d     = pat_q;
    duty_d    = duty_q;
    len_d     = len_q;
    done_d    = 1'b0;
    abt_d     = 1'b0;
    decide    = 1'b0;
    go        = 1'b0;
    src_pat   = new_pat;
    src_duty  = cmd_duty;
    src_len   = new_len;
`ifdef MOTION_SEQ_QUEUE_EN
    pend_v_d    = pend_v_q;
    pend_pat_d  = pend_pat_q;
    pend_duty_d = pend_duty_q;
    pend_len_d  = pend_len_q;
`endif
    if (oc) begin
      state_d = S_FAULT;
      cnt_d   = HOLD_LD;
      held_d  = 4'b0000;
      abt_d   = (state_q == S_DEAD) || (state_q == S_RUN);
`ifdef MOTION_SEQ_QUEUE_EN
      pend_v_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: decide = 1'b1;
        S_DEAD: begin
          if (cnt_q <= 32'd1) begin
            state_d = S_RUN;
            held_d  = pat_q;
            cnt_d   = len_q;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        S_RUN: begin
          if (cnt_q <= 32'd1) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            decide  = 1'b1;
          end else begin
            cnt_d     = cnt_q - 32'd1;
            pwm_cnt_d = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + 21'd1;
          end
        end
        S_FAULT: begin
          if (cnt_q <= 32'd1) state_d = S_IDLE;
          else cnt_d = cnt_q - 32'd1;
        end
        default: state_d = S_IDLE;
      endcase
      // A queued command launches on the same edge that frees the block.
      if (decide) begin
`ifdef MOTION_SEQ_QUEUE_EN
        if (pend_v_q) begin
          go       = 1'b1;
          src_pat  = pend_pat_q;
          src_duty = pend_duty_q;
          src_len  = pend_len_q;
          pend_v_d = 1'b0;
        end else
`endif
        if (accept) go = 1'b1;
      end
`ifdef MOTION_SEQ_QUEUE_EN
      else if (accept) begin
        pend_v_d    = 1'b1;
        pend_pat_d  = new_pat;
        pend_duty_d = cmd_duty;
        pend_len_d  = new_len;
      end
`endif
      if (go) begin
        pat_d  = src_pat;
        duty_d = src_duty;
        len_d  = src_len;
        if (src_pat != held_q) begin
          state_d = S_DEAD;
          cnt_d   = DEAD_LD;
        end else begin
          state_d = S_RUN;
          cnt_d   = src_len;
        end
      end
    end
    in_d    = (state_d == S_RUN || state_d == S_IDLE) ? held_d : 4'b0000;
    pwm_d   = (state_d == S_RUN) && (pwm_cnt_d < duty_d);
    busy_d  = state_d != S_IDLE;
    fault_d = state_d == S_FAULT;
`ifdef MOTION_SEQ_QUEUE_EN
    rdy_d   = (state_d != S_FAULT) && !pend_v_d;
`else
    rdy_d   = state_d == S_IDLE;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      pwm_cnt_q <= '0;
      duty_q    <= '0;
      held_q    <= '0;
      pat_q     <= '0;
      in_q      <= '0;
      pwm_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abt_q     <= 1'b0;
      fault_q   <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
      held_q    <= held_d;
      pat_q     <= pat_d;
      in_q      <= in_d;
      pwm_q     <= pwm_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      abt_q     <= abt_d;
      fault_q   <= fault_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef MOTION_SEQ_QUEUE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_v_q    <= 1'b0;
      pend_pat_q  <= '0;
      pend_duty_q <= '0;
      pend_len_q  <= '0;
    end else begin
      pend_v_q    <= pend_v_d;
      pend_pat_q  <= pend_pat_d;
      pend_duty_q <= pend_duty_d;
      pend_len_q  <= pend_len_d;
    end
  end
`endif

  assign {IN1, IN2, IN3, IN4} = in_q;
  assign PWMA      = pwm_q;
  assign PWMB      = pwm_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = abt_q;
  assign fault     = fault_q;
  assign cmd_ready = rdy_q;

endmodule
